// File: rtl/ooo_pkg.sv
// ooo_pkg: shared opcode/FU encodings, issue-queue defaults and entry layout
package ooo_pkg;

    localparam int IQ_DEPTH  = 8;
    localparam int IQ_PREG_W = 7;
    localparam int IQ_ROB_W  = 3;
    localparam int IQ_NUM_WB = 2;

    // opcode[6:2]
    localparam logic [4:0] LOAD   = 5'b00000;
    localparam logic [4:0] I_TYPE = 5'b00100;
    localparam logic [4:0] AUIPC  = 5'b00101;
    localparam logic [4:0] S_TYPE = 5'b01000;
    localparam logic [4:0] R_TYPE = 5'b01100;
    localparam logic [4:0] LUI    = 5'b01101;
    localparam logic [4:0] B_TYPE = 5'b11000;
    localparam logic [4:0] JALR   = 5'b11001;
    localparam logic [4:0] JAL    = 5'b11011;
    localparam logic [4:0] SYSTEM = 5'b11100;

    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_MUL    = 3'd1,
        FU_DIV    = 3'd2,
        FU_BRANCH = 3'd3,
        FU_JUMP   = 3'd4,
        FU_UPPER  = 3'd5,
        FU_LOAD   = 3'd6,
        FU_STORE  = 3'd7
    } fu_sel_e;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic [31:0]          imm;
        logic [4:0]           op;
        logic [2:0]           f3;
        logic [6:0]           f7;
        logic [IQ_PREG_W-1:0] p_rs1;
        logic [IQ_PREG_W-1:0] p_rs2;
        logic [IQ_PREG_W-1:0] p_rd;
        logic [2:0]           fu_sel;
        logic [IQ_ROB_W-1:0]  rob_idx;
        logic [1:0]           lq_tail;
        logic [1:0]           sq_tail;
        logic                 jump;
    } iq_uop_t;

    typedef struct packed {
        logic    valid;
        logic    rs1_rdy;
        logic    rs2_rdy;
        iq_uop_t uop;
    } iq_entry_t;

endpackage

// File: rtl/iq_age_select.sv
// iq_age_select: combinational picker of the oldest eligible entry by ROB age
// elig_i: eligible vector; rob_idx_i: flattened per-entry ROB index; rob_head_i: age reference
// gnt_idx_o/gnt_vld_o: winning entry index and whether any entry won
module iq_age_select
    import ooo_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int ROB_W = IQ_ROB_W
) (
    input  logic [DEPTH-1:0]         elig_i,
    input  logic [DEPTH*ROB_W-1:0]   rob_idx_i,
    input  logic [ROB_W-1:0]         rob_head_i,
    output logic [$clog2(DEPTH)-1:0] gnt_idx_o,
    output logic                     gnt_vld_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [ROB_W-1:0] age, best;

    // age wraps modulo 2^ROB_W so the entry nearest the head wins
    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        best      = '1;
        age       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = rob_idx_i[i*ROB_W +: ROB_W] - rob_head_i;
            if (elig_i[i] && (!gnt_vld_o || age < best)) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IDX_W'(i);
                best      = age;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// issue_queue: unified out-of-order issue queue, single oldest-ready issue per cycle
// clk/rst: clock and synchronous active-high reset
// DC_valid/IS_ready/DC_out_*: dispatch handshake and micro-op fields; rs*_busy: busy-table lookups
// wb_valid/wb_prd: wakeup broadcasts; rob_head: age reference; mispredict/stall: flush and hold
// iss_valid/iss_ready/iss_*: registered issue slot; count: occupied entries
module issue_queue
    import ooo_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int PREG_W = IQ_PREG_W,
    parameter int ROB_W  = IQ_ROB_W,
    parameter int NUM_WB = IQ_NUM_WB
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     DC_valid,
    output logic                     IS_ready,
    input  logic [31:0]              DC_out_pc,
    input  logic [31:0]              DC_out_inst,
    input  logic [31:0]              DC_out_imm,
    input  logic [4:0]               DC_out_op,
    input  logic [2:0]               DC_out_f3,
    input  logic [6:0]               DC_out_f7,
    input  logic [PREG_W-1:0]        DC_out_P_rs1,
    input  logic [PREG_W-1:0]        DC_out_P_rs2,
    input  logic [PREG_W-1:0]        DC_out_P_rd,
    input  logic [2:0]               DC_out_fu_sel,
    input  logic [ROB_W-1:0]         DC_out_rob_idx,
    input  logic [1:0]               DC_out_LQ_tail,
    input  logic [1:0]               DC_out_SQ_tail,
    input  logic                     DC_out_jump,
    input  logic                     rs1_busy,
    input  logic                     rs2_busy,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*PREG_W-1:0] wb_prd,
    input  logic [ROB_W-1:0]         rob_head,
    input  logic                     mispredict,
    input  logic                     stall,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [31:0]              iss_pc,
    output logic [31:0]              iss_inst,
    output logic [31:0]              iss_imm,
    output logic [4:0]               iss_op,
    output logic [2:0]               iss_f3,
    output logic [6:0]               iss_f7,
    output logic [PREG_W-1:0]        iss_P_rs1,
    output logic [PREG_W-1:0]        iss_P_rs2,
    output logic [PREG_W-1:0]        iss_P_rd,
    output logic [2:0]               iss_fu_sel,
    output logic [ROB_W-1:0]         iss_rob_idx,
    output logic [1:0]               iss_LQ_tail,
    output logic [1:0]               iss_SQ_tail,
    output logic                     iss_jump,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    iq_entry_t              ent_q [DEPTH];
    iq_entry_t              new_ent;
    iq_uop_t                iss_q;
    logic                   iss_vld_q;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DEPTH-1:0]       elig;
    logic [DEPTH*ROB_W-1:0] rob_flat;
    logic [IDX_W-1:0]       free_idx, gnt_idx;
    logic                   gnt_vld, accept, do_issue, drain;

    function automatic logic woken(input logic [PREG_W-1:0] p);
        woken = 1'b0;
        for (int k = 0; k < NUM_WB; k++)
            woken |= wb_valid[k] && (wb_prd[k*PREG_W +: PREG_W] == p);
    endfunction

    // registered count only: an issue this cycle does not open a slot for dispatch
    assign IS_ready = (count_q < CNT_W'(DEPTH)) && !mispredict && !stall;
    assign accept   = DC_valid && IS_ready;
    assign do_issue = (!iss_vld_q || iss_ready) && gnt_vld && !stall;
    assign drain    = iss_vld_q && iss_ready && !gnt_vld && !stall;
    assign count_d  = count_q + CNT_W'(accept) - CNT_W'(do_issue);

    // same-cycle wakeup bypass and p0 (hardwired zero) count as ready at allocation
    assign new_ent = '{
        valid:   1'b1,
        rs1_rdy: !rs1_busy || DC_out_P_rs1 == '0 || woken(DC_out_P_rs1),
        rs2_rdy: !rs2_busy || DC_out_P_rs2 == '0 || woken(DC_out_P_rs2),
        uop:     '{pc: DC_out_pc, inst: DC_out_inst, imm: DC_out_imm, op: DC_out_op,
                   f3: DC_out_f3, f7: DC_out_f7, p_rs1: DC_out_P_rs1, p_rs2: DC_out_P_rs2,
                   p_rd: DC_out_P_rd, fu_sel: DC_out_fu_sel, rob_idx: DC_out_rob_idx,
                   lq_tail: DC_out_LQ_tail, sq_tail: DC_out_SQ_tail, jump: DC_out_jump}
    };

    // descending scan leaves the lowest free index
    always_comb begin
        free_idx = '0;
        elig     = '0;
        rob_flat = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) free_idx = IDX_W'(i);
            elig[i] = ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
            rob_flat[i*ROB_W +: ROB_W] = ent_q[i].uop.rob_idx;
        end
    end

    iq_age_select #(.DEPTH(DEPTH), .ROB_W(ROB_W)) u_sel (
        .elig_i     (elig),
        .rob_idx_i  (rob_flat),
        .rob_head_i (rob_head),
        .gnt_idx_o  (gnt_idx),
        .gnt_vld_o  (gnt_vld)
    );

    always_ff @(posedge clk) begin
        if (rst || mispredict) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
            iss_vld_q <= 1'b0;
            iss_q     <= '0;
            count_q   <= '0;
        end else begin
            // wakeups land even while stalled; select only sees them next cycle
            for (int i = 0; i < DEPTH; i++) begin
                if (woken(ent_q[i].uop.p_rs1)) ent_q[i].rs1_rdy <= 1'b1;
                if (woken(ent_q[i].uop.p_rs2)) ent_q[i].rs2_rdy <= 1'b1;
            end
            if (do_issue) begin
                ent_q[gnt_idx].valid <= 1'b0;
                iss_q                <= ent_q[gnt_idx].uop;
                iss_vld_q            <= 1'b1;
            end else if (drain) begin
                iss_vld_q <= 1'b0;
            end
            if (accept) ent_q[free_idx] <= new_ent;
            count_q <= count_d;
        end
    end

    assign iss_valid   = iss_vld_q;
    assign iss_pc      = iss_q.pc;
    assign iss_inst    = iss_q.inst;
    assign iss_imm     = iss_q.imm;
    assign iss_op      = iss_q.op;
    assign iss_f3      = iss_q.f3;
    assign iss_f7      = iss_q.f7;
    assign iss_P_rs1   = iss_q.p_rs1;
    assign iss_P_rs2   = iss_q.p_rs2;
    assign iss_P_rd    = iss_q.p_rd;
    assign iss_fu_sel  = iss_q.fu_sel;
    assign iss_rob_idx = iss_q.rob_idx;
    assign iss_LQ_tail = iss_q.lq_tail;
    assign iss_SQ_tail = iss_q.sq_tail;
    assign iss_jump    = iss_q.jump;
    assign count       = count_q;

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Unified out-of-order issue queue on the receiving end of the decode/dispatch → IS handshake.
- Accepts renamed micro-ops from the decode stage when DC_valid && IS_ready, and holds them until both physical source operands are ready.
- Tracks operand readiness through writeback wakeup broadcasts.
- Issues at most one micro-op per cycle, oldest-first by ROB age, into a registered output slot feeding register read / FU dispatch.

Parameters:
DEPTH, 8, number of queue entries (power of 2; matches ROB size)
PREG_W, 7, physical register index width
ROB_W, 3, ROB index width
NUM_WB, 2, number of wakeup broadcast ports

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
DC_valid  in  1  dispatch request valid
IS_ready  out  1  queue can accept one entry this cycle
DC_out_pc  in  32  instruction PC
DC_out_inst  in  32  raw instruction
DC_out_imm  in  32  decoded immediate
DC_out_op  in  5  opcode[6:2]
DC_out_f3  in  3  funct3
DC_out_f7  in  7  funct7
DC_out_P_rs1  in  PREG_W  physical source 1
DC_out_P_rs2  in  PREG_W  physical source 2
DC_out_P_rd  in  PREG_W  physical destination
DC_out_fu_sel  in  3  FU class (0 alu/csr … 6 load, 7 store)
DC_out_rob_idx  in  ROB_W  ROB slot
DC_out_LQ_tail  in  2  load-queue tag
DC_out_SQ_tail  in  2  store-queue tag
DC_out_jump  in  1  predicted-taken flag
rs1_busy  in  1  busy-table lookup for DC_out_P_rs1 (combinational, this cycle)
rs2_busy  in  1  busy-table lookup for DC_out_P_rs2
wb_valid  in  NUM_WB  wakeup valid per port
wb_prd  in  NUM_WB*PREG_W  woken physical register per port
rob_head  in  ROB_W  current ROB head, used for age
mispredict  in  1  flush
stall  in  1  global hold
iss_valid  out  1  output slot holds a micro-op
iss_ready  in  1  consumer accepts the slot
iss_pc, iss_inst, iss_imm, iss_op, iss_f3, iss_f7, iss_P_rs1, iss_P_rs2, iss_P_rd, iss_fu_sel, iss_rob_idx, iss_LQ_tail, iss_SQ_tail, iss_jump  out  same widths as the DC_out_* inputs  issued micro-op fields
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset: all entry valid bits 0; count 0; iss_valid 0; all iss_* fields 0. IS_ready is 1 after reset.
- IS_ready = (count < DEPTH) && !mispredict && !stall.
  - Based on registered count only; an issue in the same cycle does not free a slot for dispatch.
- Accept when DC_valid && IS_ready. The entry is written into the lowest-index free slot at the clock edge.
- Operand readiness at allocation:
  - Source ready = !busy, OR P_rs == 0, OR it matches any wb_valid/wb_prd this cycle (same-cycle bypass).
  - Stores and branches treat rs2 normally. Unused sources arrive with busy=0 from the busy table.
- Wakeup: each cycle, every valid entry whose P_rs1/P_rs2 equals a valid wb_prd sets the corresponding ready bit at the edge.
  - Select sees the stored bits only, so wakeup-to-eligible latency is 1 cycle.
- Select:
  - Eligible = valid && rs1_rdy && rs2_rdy.
  - Pick the eligible entry with minimum age, where age = (rob_idx - rob_head) mod 2^ROB_W.
  - Ties are impossible (unique rob_idx).
- Output slot:
  - Loads the selected entry when (!iss_valid || iss_ready) && any eligible && !stall.
  - The selected entry's valid bit is cleared on that same edge.
  - If iss_valid && iss_ready and nothing is eligible, iss_valid goes to 0.
  - Otherwise the slot holds.
- Count: +1 on accept, -1 on issue into slot, unchanged when both happen.
- Latency: dispatch accepted at edge N with ready operands → eligible in cycle N+1 → iss_valid at edge N+2.
- mispredict (highest priority): at the edge, clear all entry valid bits, set count to 0, set iss_valid to 0 and zero the iss fields. No accept occurs that cycle.
- stall: no accept, no select, output slot holds. Wakeups are still recorded.
- Full (count == DEPTH): IS_ready=0; dispatch must hold its inputs.
- Empty: no select; iss_valid drains on iss_ready.
- Reset asserted mid-operation overrides everything and returns the block to the reset state at the next edge.

Decomposition:
- Shared package ooo_pkg holds:
  - opcode constants (R_TYPE, LOAD, S_TYPE, …)
  - FU-select encodings
  - iq_entry_t packed struct: the dispatch fields plus rs1_rdy, rs2_rdy, valid
  - DEPTH/PREG_W defaults
- One natural sub-module: iq_age_select, a combinational oldest-eligible picker taking eligible vector, rob_idx array and rob_head, returning grant index and grant valid.

Test Plan:
- Reset, then dispatch ADD with rs1_busy=0, rs2_busy=0, rob_idx=0 → iss_valid=1 two cycles later with iss_rob_idx=0; count returns to 0.
- Dispatch entry A (P_rs1=12, busy); wb_valid[0]=1, wb_prd=12 three cycles later → A issues exactly 2 cycles after the wakeup; same-cycle wakeup at dispatch → issues at N+2.
- rob_head=6; entries with rob_idx 1, 7, 6, all ready, held with iss_ready=0 then released → issue order 6, 7, 1.
- Fill 8 entries with busy sources → IS_ready=0 and count=8; one wakeup frees a slot → IS_ready=1 the cycle after issue.
- Queue holds 5 entries with iss_valid=1, then pulse mispredict → next cycle count=0, iss_valid=0, and a DC_valid presented during the flush cycle is not accepted.
- stall held 3 cycles with a wakeup for P_rs2=40 during the stall → no issue or accept while stalled; the dependent entry issues after the stall drops.
